sprite_addr_gen: RTL and testbench
==================================

Name: sprite_addr_gen

Overview:
- Parametrised multi-sprite address generator for the VGA pixel path. Successor to the fixed two-character generator.
- Holds NUM_SPR sprite descriptors, double-buffered and committed at frame start. Hit-tests each descriptor against the scan position and resolves priority.
- Computes the BRAM address for the winning sprite, or passes through a background/tile address supplied by the tile engine.
- Emits show/sprite-hit flags delay-aligned to BRAM read data.

Parameters:
- NUM_SPR, 2, number of sprite channels (1..8); index 0 has highest priority.
- SPR_W, 32, sprite cell width in pixels (power of two).
- SPR_H, 32, sprite cell height in pixels (power of two).
- IDLE_FRAMES, 4, idle-strip frame count; idle stride = IDLE_FRAMES*SPR_W.
- WALK_FRAMES, 6, walk-strip frame count; walk stride = WALK_FRAMES*SPR_W.
- INSET_X, 3, left/right transparent inset excluded from the hit box.
- INSET_TOP, 5, top rows excluded from the hit box.
- ADDR_W, 17, pixel address width.
- BRAM_LAT, 2, BRAM read latency in clocks.

Ports:
- clk  in  1  25 MHz pixel clock
- rst  in  1  asynchronous reset, active-high
- h_cnt  in  10  scan X
- v_cnt  in  10  scan Y
- vsync  in  1  VGA vsync (level, clk domain)
- cfg_we  in  1  descriptor write strobe
- cfg_idx  in  3  channel written (values >= NUM_SPR ignored)
- cfg_en  in  1  channel enable
- cfg_x  in  10  sprite left X
- cfg_y  in  10  sprite top Y
- cfg_frame  in  3  animation frame
- cfg_moving  in  1  1 = walk strip, 0 = idle strip
- cfg_left  in  1  horizontal mirror
- cfg_idle_base  in  ADDR_W  idle-strip base address
- cfg_walk_base  in  ADDR_W  walk-strip base address
- bg_valid  in  1  background/tile pixel present at this h/v
- bg_addr  in  ADDR_W  background address at this h/v
- pixel_addr  out  ADDR_W  BRAM address (registered)
- out_show_pixel  out  1  pixel visible, aligned to BRAM data
- out_spr_hit  out  NUM_SPR  one-hot winning sprite, aligned to BRAM data
- out_bg_sync  out  1  background selected, aligned to BRAM data

Behaviour:
- Reset: all descriptors in both banks cleared (disabled, zero). All pipeline registers zero. pixel_addr=0, out_show_pixel=0, out_spr_hit=0, out_bg_sync=0.
- Descriptor banks:
  - cfg_we writes the pending bank for cfg_idx in one cycle, with no back-pressure.
  - Active bank <= pending bank on the clk cycle after the detected vsync rising edge. The edge is detected with a 1-flop history in the clk domain, not by clocking on vsync.
  - A write in the same cycle as the commit lands in pending only; active takes the pre-write pending value.
- Stage 0 (T+1, registered): per channel, hit = en && x+INSET_X <= h < x+SPR_W-INSET_X && y+INSET_TOP <= v < y+SPR_H.
  - Compares use 11-bit arithmetic, so sprites near 1023 do not wrap.
  - Priority encoder picks the lowest hit index. Registers local rx=h-x and ly=v-y (log2 widths), sel id, any_hit, bg_valid, bg_addr.
- Frame clamp: if frame >= the selected strip's frame count, frame 0 is used.
- Stage 1 (T+2, registered), pixel_addr:
  - any_hit: base + ly*stride + (left ? SPR_W-1-rx : rx) + frame*SPR_W.
  - else bg_valid: bg_addr.
  - else: 0.
  - Sprites always override background.
- Alignment: show, hit one-hot and bg flag are delayed so they appear at T+2+BRAM_LAT (T+4 default), the same cycle BRAM data for pixel_addr appears.
  - out_show_pixel = any_hit || bg_valid.
  - out_bg_sync = bg_valid && !any_hit.
- Outside the active area (h >= 640 or v >= 480): no hits. bg_valid is passed through as given.
- Address arithmetic is truncated to ADDR_W; no saturation.

Optional Feature:
- SPR_VFLIP_EN:
  - When defined, each descriptor gains a cfg_vflip input bit (double-buffered like the others).
  - The vertical row becomes SPR_H-1-ly in stage 1.
  - Without it, the port is absent and rows are never flipped.

Decomposition:
- Shared package sprite_pkg: descriptor struct (en, x, y, frame, moving, left[, vflip], bases), screen size constants (640/480), and the strip kind enum.
- One natural sub-module: spr_prio_enc, the parametrised lowest-index-wins encoder producing one-hot, index and any.

Test Plan:
- Reset mid-frame with sprites live -> all outputs 0 next cycle. After release, no sprite shows until a cfg write and a vsync edge.
- ch0 at (100,200), idle, frame 1, idle_base 1024; scan h=110, v=210 -> pixel_addr=1024+10*128+10+32=2346 at T+2; out_show_pixel=1 and out_spr_hit=01 at T+4.
- Same point with cfg_left=1 -> lx=31-10+32=53, pixel_addr=2357.
- ch0 and ch1 overlap at the same point, bg_valid=1, bg_addr=500 -> ch0 wins (hit=01). With ch0 disabled -> ch1 wins. With both disabled -> pixel_addr=500, out_bg_sync=1.
- Write ch0 x=300 mid-frame -> position unchanged until vsync rising edge. Write coinciding with the commit cycle -> appears only after the following vsync.
- Edge bounds: h=x+2 -> no hit; h=x+3 -> hit; h=x+29 -> no hit. cfg_frame=7 on walk strip -> frame 0 address used.

Source files
------------

// File: rtl/sprite_pkg.sv
// sprite_pkg: shared descriptor type, screen limits and strip kinds for sprite_addr_gen (SPR_VFLIP_EN adds vflip)
package sprite_pkg;
  localparam int SCR_W = 640;
  localparam int SCR_H = 480;
  localparam int DESC_ADDR_W = 32;
  typedef enum logic {STRIP_IDLE = 1'b0, STRIP_WALK = 1'b1} strip_e;
  typedef struct packed {
    logic en;
    logic [9:0] x;
    logic [9:0] y;
    logic [2:0] frame;
    strip_e kind;
    logic left;
`ifdef SPR_VFLIP_EN
    logic vflip;
`endif
    logic [DESC_ADDR_W-1:0] idle_base;
    logic [DESC_ADDR_W-1:0] walk_base;
  } spr_desc_t;
endpackage

// File: rtl/sprite_addr_gen_if.sv
// sprite_addr_gen_if: scan, descriptor config, background and BRAM-side signals of sprite_addr_gen (SPR_VFLIP_EN adds cfg_vflip)
interface sprite_addr_gen_if #(
  parameter int NUM_SPR = 2,
  parameter int ADDR_W = 17
);
  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic vsync;
  logic cfg_we;
  logic [2:0] cfg_idx;
  logic cfg_en;
  logic [9:0] cfg_x;
  logic [9:0] cfg_y;
  logic [2:0] cfg_frame;
  logic cfg_moving;
  logic cfg_left;
`ifdef SPR_VFLIP_EN
  logic cfg_vflip;
`endif
  logic [ADDR_W-1:0] cfg_idle_base;
  logic [ADDR_W-1:0] cfg_walk_base;
  logic bg_valid;
  logic [ADDR_W-1:0] bg_addr;
  logic [ADDR_W-1:0] pixel_addr;
  logic out_show_pixel;
  logic [NUM_SPR-1:0] out_spr_hit;
  logic out_bg_sync;
  modport master (
    output h_cnt, v_cnt, vsync, cfg_we, cfg_idx, cfg_en, cfg_x, cfg_y, cfg_frame, cfg_moving, cfg_left,
`ifdef SPR_VFLIP_EN
    output cfg_vflip,
`endif
    output cfg_idle_base, cfg_walk_base, bg_valid, bg_addr,
    input pixel_addr, out_show_pixel, out_spr_hit, out_bg_sync
  );
  modport slave (
    input h_cnt, v_cnt, vsync, cfg_we, cfg_idx, cfg_en, cfg_x, cfg_y, cfg_frame, cfg_moving, cfg_left,
`ifdef SPR_VFLIP_EN
    input cfg_vflip,
`endif
    input cfg_idle_base, cfg_walk_base, bg_valid, bg_addr,
    output pixel_addr, out_show_pixel, out_spr_hit, out_bg_sync
  );
endinterface

// File: rtl/spr_prio_enc.sv
// spr_prio_enc: lowest-index-wins priority encoder giving one-hot, index and any
module spr_prio_enc #(
  parameter int N = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          any
);
  // scan from the top so the lowest requesting index is the last one written
  always_comb begin
    onehot = '0;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      onehot = req[i] ? N'(1) << i : onehot;
      idx = req[i] ? IW'(i) : idx;
    end
  end
  assign any = |req;
endmodule

// File: rtl/sprite_addr_gen.sv
// sprite_addr_gen: multi-sprite BRAM address generator with double-buffered descriptors (SPR_VFLIP_EN adds vertical flip)
module sprite_addr_gen
  import sprite_pkg::*;
#(
  parameter int NUM_SPR = 2,
  parameter int SPR_W = 32,
  parameter int SPR_H = 32,
  parameter int IDLE_FRAMES = 4,
  parameter int WALK_FRAMES = 6,
  parameter int INSET_X = 3,
  parameter int INSET_TOP = 5,
  parameter int ADDR_W = 17,
  parameter int BRAM_LAT = 2
) (
  input logic clk,
  input logic rst,
  sprite_addr_gen_if.slave bus
);
  localparam int IDX_W = NUM_SPR > 1 ? $clog2(NUM_SPR) : 1;
  localparam int RX_W = $clog2(SPR_W);
  localparam int LY_W = $clog2(SPR_H);
  localparam int FW = NUM_SPR + 2;
  spr_desc_t pend [NUM_SPR];
  spr_desc_t act [NUM_SPR];
  spr_desc_t wr_desc;
  logic vsync_q;
  logic commit;
  logic [10:0] h11;
  logic [10:0] v11;
  logic in_area;
  logic [NUM_SPR-1:0] hit;
  logic [NUM_SPR-1:0] hit_oh;
  logic [IDX_W-1:0] sel;
  logic any;
  logic [NUM_SPR-1:0] s0_hit;
  logic s0_any;
  logic s0_bgv;
  logic [ADDR_W-1:0] s0_bga;
  logic [RX_W-1:0] s0_rx;
  logic [LY_W-1:0] s0_ly;
  strip_e s0_kind;
  logic [2:0] s0_frame;
  logic s0_left;
`ifdef SPR_VFLIP_EN
  logic s0_vflip;
`endif
  logic [ADDR_W-1:0] s0_base;
  int fcnt;
  logic [2:0] frm;
  logic [RX_W-1:0] col;
  logic [LY_W-1:0] row;
  logic [ADDR_W-1:0] spr_addr;
  logic [FW-1:0] pipe [BRAM_LAT+1];
  assign commit = bus.vsync && !vsync_q;
  assign h11 = {1'b0, bus.h_cnt};
  assign v11 = {1'b0, bus.v_cnt};
  assign in_area = bus.h_cnt < 10'(SCR_W) && bus.v_cnt < 10'(SCR_H);
  // pack the config inputs into one descriptor record
  always_comb begin
    wr_desc = '0;
    wr_desc.en = bus.cfg_en;
    wr_desc.x = bus.cfg_x;
    wr_desc.y = bus.cfg_y;
    wr_desc.frame = bus.cfg_frame;
    wr_desc.kind = strip_e'(bus.cfg_moving);
    wr_desc.left = bus.cfg_left;
`ifdef SPR_VFLIP_EN
    wr_desc.vflip = bus.cfg_vflip;
`endif
    wr_desc.idle_base = DESC_ADDR_W'(bus.cfg_idle_base);
    wr_desc.walk_base = DESC_ADDR_W'(bus.cfg_walk_base);
  end
  // pending bank takes writes; active bank copies the pre-write pending bank on a vsync rising edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vsync_q <= 1'b0;
      for (int i = 0; i < NUM_SPR; i++) begin
        pend[i] <= '0;
        act[i] <= '0;
      end
    end else begin
      vsync_q <= bus.vsync;
      for (int i = 0; i < NUM_SPR; i++) begin
        if (commit) act[i] <= pend[i];
        if (bus.cfg_we && bus.cfg_idx == 3'(i)) pend[i] <= wr_desc;
      end
    end
  end
  // 11-bit hit boxes so sprites near the right/bottom edge of the counter range never wrap
  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_SPR; i++)
      hit[i] = in_area && act[i].en &&
               h11 >= {1'b0, act[i].x} + 11'(INSET_X) && h11 < {1'b0, act[i].x} + 11'(SPR_W - INSET_X) &&
               v11 >= {1'b0, act[i].y} + 11'(INSET_TOP) && v11 < {1'b0, act[i].y} + 11'(SPR_H);
  end
  spr_prio_enc #(.N(NUM_SPR), .IW(IDX_W)) u_prio (
    .req(hit),
    .onehot(hit_oh),
    .idx(sel),
    .any(any)
  );
  // stage 0: latch the winner's local coordinates and the fields stage 1 needs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_hit <= '0;
      s0_any <= 1'b0;
      s0_bgv <= 1'b0;
      s0_bga <= '0;
      s0_rx <= '0;
      s0_ly <= '0;
      s0_kind <= STRIP_IDLE;
      s0_frame <= '0;
      s0_left <= 1'b0;
`ifdef SPR_VFLIP_EN
      s0_vflip <= 1'b0;
`endif
      s0_base <= '0;
    end else begin
      s0_hit <= hit_oh;
      s0_any <= any;
      s0_bgv <= bus.bg_valid;
      s0_bga <= bus.bg_addr;
      s0_rx <= RX_W'(bus.h_cnt - act[sel].x);
      s0_ly <= LY_W'(bus.v_cnt - act[sel].y);
      s0_kind <= act[sel].kind;
      s0_frame <= act[sel].frame;
      s0_left <= act[sel].left;
`ifdef SPR_VFLIP_EN
      s0_vflip <= act[sel].vflip;
`endif
      s0_base <= ADDR_W'(act[sel].kind == STRIP_WALK ? act[sel].walk_base : act[sel].idle_base);
    end
  end
  // strip address: row*stride + mirrored column + clamped frame offset, truncated to ADDR_W
  always_comb begin
    fcnt = s0_kind == STRIP_WALK ? WALK_FRAMES : IDLE_FRAMES;
    frm = int'(s0_frame) >= fcnt ? 3'd0 : s0_frame;
    col = s0_left ? RX_W'(SPR_W - 1) - s0_rx : s0_rx;
`ifdef SPR_VFLIP_EN
    row = s0_vflip ? LY_W'(SPR_H - 1) - s0_ly : s0_ly;
`else
    row = s0_ly;
`endif
    spr_addr = s0_base + ADDR_W'(row) * ADDR_W'(fcnt * SPR_W) + ADDR_W'(col) + ADDR_W'(frm) * ADDR_W'(SPR_W);
  end
  // stage 1: address register plus flag delay line matching the BRAM read latency
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.pixel_addr <= '0;
      for (int i = 0; i <= BRAM_LAT; i++) pipe[i] <= '0;
    end else begin
      bus.pixel_addr <= s0_any ? spr_addr : s0_bgv ? s0_bga : '0;
      pipe[0] <= {s0_any || s0_bgv, s0_bgv && !s0_any, s0_hit};
      for (int i = 1; i <= BRAM_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign bus.out_show_pixel = pipe[BRAM_LAT][FW-1];
  assign bus.out_bg_sync = pipe[BRAM_LAT][FW-2];
  assign bus.out_spr_hit = pipe[BRAM_LAT][NUM_SPR-1:0];
endmodule

// File: tb/tb_sprite_addr_gen.sv
// tb_sprite_addr_gen: table-driven scoreboard bench for sprite_addr_gen
module tb_sprite_addr_gen;
  typedef struct {
    int h;
    int v;
    bit bgv;
    int bga;
    int addr;
    bit [1:0] hit;
    bit show;
    bit bg;
    string nm;
  } vec_t;
  typedef struct {
    int due;
    int addr;
    bit [1:0] hit;
    bit show;
    bit bg;
    string nm;
  } sb_t;
  logic clk = 0;
  logic rst = 0;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  vec_t vecs [11];
  sb_t aq [$];
  sb_t fq [$];
  sb_t ea;
  sb_t ef;
  sprite_addr_gen_if #(.NUM_SPR(2), .ADDR_W(17)) bus ();
  sprite_addr_gen #(.NUM_SPR(2), .ADDR_W(17), .BRAM_LAT(2)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );
  always #20 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    while (aq.size() > 0 && aq[0].due <= cyc) begin
      ea = aq.pop_front();
      checks++;
      if (ea.due != cyc || bus.pixel_addr !== 17'(ea.addr)) begin
        errors++;
        $display("FAIL %s addr got %0d exp %0d", ea.nm, bus.pixel_addr, ea.addr);
      end
    end
    while (fq.size() > 0 && fq[0].due <= cyc) begin
      ef = fq.pop_front();
      checks++;
      if (ef.due != cyc || {bus.out_show_pixel, bus.out_bg_sync, bus.out_spr_hit} !== {ef.show, ef.bg, ef.hit}) begin
        errors++;
        $display("FAIL %s flags got show=%b bg=%b hit=%b exp show=%b bg=%b hit=%b", ef.nm,
                 bus.out_show_pixel, bus.out_bg_sync, bus.out_spr_hit, ef.show, ef.bg, ef.hit);
      end
    end
  end
  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", nm, got, exp);
    end
  endtask
  task automatic drive(input int h, input int v, input bit bgv, input int bga, input int addr,
                       input bit [1:0] hit, input bit show, input bit bg, input string nm);
    @(negedge clk);
    bus.h_cnt = 10'(h);
    bus.v_cnt = 10'(v);
    bus.bg_valid = bgv;
    bus.bg_addr = 17'(bga);
    aq.push_back('{cyc + 2, addr, hit, show, bg, nm});
    fq.push_back('{cyc + 4, addr, hit, show, bg, nm});
  endtask
  task automatic drain();
    int n = 0;
    while ((aq.size() > 0 || fq.size() > 0) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (aq.size() > 0 || fq.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain pending got %0d exp 0", aq.size() + fq.size());
      aq.delete();
      fq.delete();
    end
  endtask
  task automatic set_cfg(input int idx, input bit en, input int x, input int y, input int frame,
                         input bit mv, input bit left, input int ib, input int wb);
    bus.cfg_idx = 3'(idx);
    bus.cfg_en = en;
    bus.cfg_x = 10'(x);
    bus.cfg_y = 10'(y);
    bus.cfg_frame = 3'(frame);
    bus.cfg_moving = mv;
    bus.cfg_left = left;
    bus.cfg_idle_base = 17'(ib);
    bus.cfg_walk_base = 17'(wb);
  endtask
  task automatic cfg(input int idx, input bit en, input int x, input int y, input int frame,
                     input bit mv, input bit left, input int ib, input int wb);
    @(negedge clk);
    set_cfg(idx, en, x, y, frame, mv, left, ib, wb);
    bus.cfg_we = 1'b1;
    @(negedge clk);
    bus.cfg_we = 1'b0;
  endtask
  task automatic vs();
    @(negedge clk);
    bus.vsync = 1'b1;
    repeat (3) @(negedge clk);
    bus.vsync = 1'b0;
  endtask
  initial begin
    vecs[0] = '{110, 210, 0, 0, 2346, 2'b01, 1, 0, "ch0_idle"};
    vecs[1] = '{110, 210, 1, 500, 2346, 2'b01, 1, 0, "spr_over_bg"};
    vecs[2] = '{103, 205, 0, 0, 1699, 2'b01, 1, 0, "box_topleft"};
    vecs[3] = '{102, 210, 1, 77, 77, 2'b00, 1, 1, "left_inset"};
    vecs[4] = '{129, 210, 0, 0, 0, 2'b00, 0, 0, "right_inset"};
    vecs[5] = '{128, 231, 0, 0, 5052, 2'b01, 1, 0, "box_botright"};
    vecs[6] = '{110, 204, 0, 0, 0, 2'b00, 0, 0, "top_inset"};
    vecs[7] = '{110, 232, 1, 9, 9, 2'b00, 1, 1, "below_box"};
    vecs[8] = '{630, 110, 0, 0, 21994, 2'b10, 1, 0, "ch1_walk"};
    vecs[9] = '{645, 110, 1, 123, 123, 2'b00, 1, 1, "off_screen"};
    vecs[10] = '{300, 300, 0, 0, 0, 2'b00, 0, 0, "empty"};
    bus.h_cnt = '0;
    bus.v_cnt = '0;
    bus.vsync = 1'b0;
    bus.cfg_we = 1'b0;
    set_cfg(0, 0, 0, 0, 0, 0, 0, 0, 0);
`ifdef SPR_VFLIP_EN
    bus.cfg_vflip = 1'b0;
`endif
    bus.bg_valid = 1'b0;
    bus.bg_addr = '0;
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_addr", int'(bus.pixel_addr), 0);
    chk("rst_show", int'(bus.out_show_pixel), 0);
    chk("rst_hit", int'(bus.out_spr_hit), 0);
    chk("rst_bg", int'(bus.out_bg_sync), 0);
    rst = 1'b0;
    cfg(0, 1, 100, 200, 1, 0, 0, 1024, 4096);
    cfg(1, 1, 620, 100, 2, 1, 0, 0, 20000);
    vs();
    for (int i = 0; i < 11; i++)
      drive(vecs[i].h, vecs[i].v, vecs[i].bgv, vecs[i].bga, vecs[i].addr, vecs[i].hit, vecs[i].show, vecs[i].bg, vecs[i].nm);
    drain();
    cfg(0, 1, 100, 200, 1, 0, 1, 1024, 4096);
    vs();
    drive(110, 210, 0, 0, 2357, 2'b01, 1, 0, "mirror");
    cfg(0, 1, 100, 200, 7, 1, 0, 1024, 4096);
    vs();
    drive(110, 210, 0, 0, 6026, 2'b01, 1, 0, "clamp_walk7");
    cfg(0, 1, 100, 200, 5, 1, 0, 1024, 4096);
    vs();
    drive(110, 210, 0, 0, 6186, 2'b01, 1, 0, "walk5");
    cfg(0, 1, 100, 200, 4, 0, 0, 1024, 4096);
    vs();
    drive(110, 210, 0, 0, 2314, 2'b01, 1, 0, "clamp_idle4");
    cfg(0, 1, 100, 200, 1, 0, 0, 1024, 4096);
    cfg(1, 1, 100, 200, 0, 0, 0, 8192, 0);
    vs();
    drive(110, 210, 1, 500, 2346, 2'b01, 1, 0, "ovl_ch0");
    cfg(0, 0, 100, 200, 1, 0, 0, 1024, 4096);
    vs();
    drive(110, 210, 1, 500, 9482, 2'b10, 1, 0, "ovl_ch1");
    cfg(1, 0, 100, 200, 0, 0, 0, 8192, 0);
    vs();
    drive(110, 210, 1, 500, 500, 2'b00, 1, 1, "ovl_bg");
    cfg(5, 1, 100, 200, 0, 0, 0, 8192, 0);
    vs();
    drive(110, 210, 1, 500, 500, 2'b00, 1, 1, "idx_ignored");
    drain();
    cfg(0, 1, 100, 200, 1, 0, 0, 1024, 4096);
    vs();
    cfg(0, 1, 300, 200, 1, 0, 0, 1024, 4096);
    drive(110, 210, 0, 0, 2346, 2'b01, 1, 0, "pre_commit_old");
    drive(310, 210, 0, 0, 0, 2'b00, 0, 0, "pre_commit_new");
    vs();
    drive(310, 210, 0, 0, 2346, 2'b01, 1, 0, "post_commit_new");
    drive(110, 210, 0, 0, 0, 2'b00, 0, 0, "post_commit_old");
    @(negedge clk);
    bus.vsync = 1'b1;
    set_cfg(0, 1, 500, 200, 1, 0, 0, 1024, 4096);
    bus.cfg_we = 1'b1;
    @(negedge clk);
    bus.cfg_we = 1'b0;
    repeat (2) @(negedge clk);
    bus.vsync = 1'b0;
    drive(310, 210, 0, 0, 2346, 2'b01, 1, 0, "coincide_keep");
    drive(510, 210, 0, 0, 0, 2'b00, 0, 0, "coincide_pending");
    vs();
    drive(510, 210, 0, 0, 2346, 2'b01, 1, 0, "coincide_next");
    drive(310, 210, 0, 0, 0, 2'b00, 0, 0, "coincide_old_gone");
    drive(510, 210, 0, 0, 2346, 2'b01, 1, 0, "live_before_rst");
    drain();
    repeat (3) @(negedge clk);
    #5 rst = 1'b1;
    #1;
    chk("midrst_addr", int'(bus.pixel_addr), 0);
    chk("midrst_show", int'(bus.out_show_pixel), 0);
    chk("midrst_hit", int'(bus.out_spr_hit), 0);
    chk("midrst_bg", int'(bus.out_bg_sync), 0);
    @(negedge clk);
    rst = 1'b0;
    drive(510, 210, 0, 0, 0, 2'b00, 0, 0, "post_rst_nohit");
    cfg(0, 1, 500, 200, 1, 0, 0, 1024, 4096);
    drive(510, 210, 0, 0, 0, 2'b00, 0, 0, "cfg_no_vsync");
    vs();
    drive(510, 210, 0, 0, 2346, 2'b01, 1, 0, "cfg_after_vsync");
    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
